cpu_divide_unit: RTL
====================

Name: cpu_divide_unit

Overview:
- Parametrised multi-cycle integer divide/modulo unit for the moxie execute stage.
- Implements DIV_L, UDIV_L, MOD_L and UMOD_L, which the single-cycle execute path does not compute.
- Radix-2 restoring divider with a start/ready/valid handshake, pipeline-flush abort, a destination-register tag carried through, and defined divide-by-zero and overflow results.
- The execute stage stalls issue while ready_o is low and writes result_o to register tag_o when valid_o pulses.

Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥2.
- TAG_WIDTH, 4: width of the destination-register tag.
- CNT_WIDTH, 6: iteration counter width; must satisfy 2^CNT_WIDTH > WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  pipeline flush; aborts any operation in progress.
- start_i  input  1  request an operation; accepted only when ready_o=1 and flush_i=0.
- op_i  input  2  operation: 00 DIV (signed quotient), 01 UDIV, 10 MOD (signed remainder), 11 UMOD.
- dividend_i  input  WIDTH  dividend (regA).
- divisor_i  input  WIDTH  divisor (regB).
- tag_i  input  TAG_WIDTH  destination register index.
- ready_o  output  1  unit idle; can accept start_i.
- valid_o  output  1  one-cycle pulse; result_o and tag_o are valid.
- result_o  output  WIDTH  quotient or remainder, as selected by op_i.
- tag_o  output  TAG_WIDTH  tag latched at accept.
- dbz_o  output  1  qualifies valid_o; high when the divisor was zero.

Behaviour:
- Reset (rst_i=0, asynchronous) values:
  - state=IDLE, ready_o=1, valid_o=0.
  - result_o=0, tag_o=0, dbz_o=0.
  - internal counter, partial remainder and quotient cleared.
- States:
  - IDLE: ready_o=1.
  - CALC: ready_o=0.
  - FIX: ready_o=0.
- Accept: on a rising edge with state=IDLE, start_i=1 and flush_i=0:
  - latch op, tag, dividend sign and divisor sign.
  - signed ops: load absolute values, two's-complement negation modulo 2^WIDTH.
  - unsigned ops: load operands unchanged.
- Special cases are decided at accept:
  - divisor=0 selects the special path.
  - signed op with dividend=100…0 and divisor=all-ones selects the special path.
  - the special path goes IDLE→FIX; every other accept goes IDLE→CALC with counter=WIDTH-1.
- CALC, one restoring step per cycle:
  - remainder:quotient shifts left one bit.
  - trial = remainder − |divisor|, computed WIDTH+1 bits wide.
  - if the trial is non-negative, keep it and set the new quotient LSB to 1; otherwise set it to 0.
  - when counter=0, go to FIX; otherwise decrement the counter.
- FIX:
  - negate the quotient when the dividend and divisor signs differ (signed ops only).
  - the remainder takes the dividend's sign (signed ops only); a zero remainder stays zero.
  - register result_o, tag_o and dbz_o; valid_o=1 for exactly one cycle; go to IDLE.
- Special results:
  - divide-by-zero: quotient=all-ones, remainder=dividend, dbz_o=1.
  - overflow: quotient=100…0, remainder=0, dbz_o=0.
- Latency from the accept edge to the edge that raises valid_o:
  - normal operation: WIDTH+1 edges (33 for WIDTH=32).
  - special path: 1 edge.
- Output timing:
  - valid_o is low on every other cycle.
  - result_o, tag_o and dbz_o hold their values until the next FIX.
- Back-to-back operation:
  - while valid_o=1 the state is IDLE, so ready_o=1 in that same cycle.
  - a start_i in that cycle is accepted.
- Flush:
  - flush_i=1 at any edge forces the state to IDLE and valid_o=0.
  - the operation is discarded and the outputs are not updated.
  - flush_i together with start_i in IDLE: the start is not accepted.
  - flush_i in FIX: no valid_o pulse.
- A start_i while ready_o=0 is ignored; it is neither queued nor an error.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
1. UDIV 100/7, tag 5 → valid_o pulses exactly 33 cycles after accept; result_o=14, tag_o=5, dbz_o=0; UMOD 100/7 → result_o=2.
2. Signed signs:
   - DIV −7/2 → 0xFFFFFFFD (−3); MOD −7/2 → 0xFFFFFFFF (−1).
   - DIV 7/−2 → −3; MOD 7/−2 → 1.
   - DIV −8/−2 → 4; MOD −8/−2 → 0.
3. Specials:
   - UDIV 5/0 → valid 1 cycle after accept; result 0xFFFFFFFF, dbz_o=1.
   - UMOD 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000 in 1 cycle.
   - MOD 0x80000000/0xFFFFFFFF → 0.
4. Flush:
   - flush_i at cycle 10 of CALC → ready_o=1 next cycle, no valid_o pulse, result_o unchanged.
   - flush_i together with start_i in IDLE → no accept.
5. Back-to-back: start_i asserted in the valid_o cycle → second op accepted; its result appears 33 cycles later. start_i pulses while busy → ignored.
6. Reset and parameters:
   - rst_i=0 asynchronously mid-CALC → all outputs at reset values without a clock edge; recovery to IDLE.
   - WIDTH=8 rerun: UDIV 255/16=15, latency 9 cycles.

Source files
------------

// File: rtl/cpu_divide_unit.sv
// Multi-cycle radix-2 restoring divide/modulo unit (DIV, UDIV, MOD, UMOD) for the execute stage.
// Divide-by-zero and signed overflow bypass the iteration and resolve directly in FIX.
module cpu_divide_unit #(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = 4,
   parameter int CNT_WIDTH = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 start_i,
   input  logic [1:0]           op_i,
   input  logic [WIDTH-1:0]     dividend_i,
   input  logic [WIDTH-1:0]     divisor_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output logic [WIDTH-1:0]     result_o,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic                 dbz_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   localparam logic [WIDTH-1:0]     MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(WIDTH-1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
   logic [1:0]           op_q;
   logic                 sa_q, sb_q, dbz_q, ovf_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 valid_q, dbz_out_q;
   logic [WIDTH-1:0]     result_q;
   logic [TAG_WIDTH-1:0] tag_out_q;

   logic                 acc_signed, acc_neg_a, acc_neg_b, acc_dbz, acc_ovf;
   logic [WIDTH-1:0]     acc_abs_a, acc_abs_b;
   logic [WIDTH:0]       rem_sh, trial;
   logic [WIDTH-1:0]     rem_d, quo_d, q_fix, r_fix, res_d;
   logic                 fix_signed;

   always_comb begin
      acc_signed = ~op_i[0];
      acc_neg_a  = acc_signed & dividend_i[WIDTH-1];
      acc_neg_b  = acc_signed & divisor_i[WIDTH-1];
      acc_abs_a  = acc_neg_a ? -dividend_i : dividend_i;
      acc_abs_b  = acc_neg_b ? -divisor_i  : divisor_i;
      acc_dbz    = (divisor_i == '0);
      acc_ovf    = acc_signed & (dividend_i == MIN_VAL) & (divisor_i == '1);

      // Shifted remainder needs WIDTH+1 bits; the trial's MSB is its sign.
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      rem_d  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

      fix_signed = ~op_q[0];
      q_fix = (fix_signed & (sa_q ^ sb_q)) ? -quo_q : quo_q;
      r_fix = (fix_signed & sa_q) ? -rem_q : rem_q;
      // On the special path quo_q holds the raw dividend.
      if (dbz_q) begin
         q_fix = '1;
         r_fix = quo_q;
      end else if (ovf_q) begin
         q_fix = MIN_VAL;
         r_fix = '0;
      end
      res_d = op_q[1] ? r_fix : q_fix;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         op_q      <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
         tag_q     <= '0;
         valid_q   <= 1'b0;
         dbz_out_q <= 1'b0;
         result_q  <= '0;
         tag_out_q <= '0;
      end else begin
         valid_q <= 1'b0;
         if (flush_i) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_i) begin
                     op_q  <= op_i;
                     tag_q <= tag_i;
                     sa_q  <= acc_neg_a;
                     sb_q  <= acc_neg_b;
                     dbz_q <= acc_dbz;
                     ovf_q <= acc_ovf;
                     cnt_q <= CNT_INIT;
                     rem_q <= '0;
                     quo_q <= (acc_dbz | acc_ovf) ? dividend_i : acc_abs_a;
                     dvs_q <= acc_abs_b;
                     state_q <= (acc_dbz | acc_ovf) ? S_FIX : S_CALC;
                  end
               end
               S_CALC: begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  if (cnt_q == '0) state_q <= S_FIX;
                  else             cnt_q   <= cnt_q - CNT_ONE;
               end
               S_FIX: begin
                  result_q  <= res_d;
                  tag_out_q <= tag_q;
                  dbz_out_q <= dbz_q;
                  valid_q   <= 1'b1;
                  state_q   <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign ready_o  = (state_q == S_IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign tag_o    = tag_out_q;
   assign dbz_o    = dbz_out_q;

endmodule
